bcd_counter_multi: RTL and testbench

- Parametrised multi-digit synchronous BCD up/down counter; the next generation of the single-digit BCD counter.
- Chains DIGITS decade cells with ripple-free lookahead carry and a programmable decimal terminal value (MAX_COUNT), so one instance covers 0-99, 0-59 (minutes/seconds) or 0-9999 style timekeeping.
- Adds a wrap/saturate mode.
- Sits in display/timekeeping datapaths; its CO output cascades into the next counter's ENABLE.

---
 rtl/bcd_pkg.sv | 32 +++
 rtl/bcd_digit_cell.sv | 49 ++++
 rtl/bcd_counter_multi.sv | 160 ++++++++++++++++
 tb/tb_bcd_counter_multi.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD types, constants and helper functions
//
// Purpose : common definitions for the multi-digit BCD counter.
//   BCD_W          : bits per decade
//   BCD_MAX_DIGITS : widest supported counter (8 decades, 32 bits)
//   bcd_digit_t    : one decade
//   to_bcd()       : integer -> packed BCD, used at elaboration time
//   is_bcd_valid() : nibble holds a legal decimal digit
package bcd_pkg;

    localparam int BCD_W          = 4;
    localparam int BCD_MAX_DIGITS = 8;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    function automatic logic [BCD_W*BCD_MAX_DIGITS-1:0] to_bcd(input int value);
        logic [BCD_W*BCD_MAX_DIGITS-1:0] res;
        int v;
        res = '0;
        v   = value;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            res[i*BCD_W +: BCD_W] = bcd_digit_t'(v % 10);
            v = v / 10;
        end
        return res;
    endfunction

    function automatic logic is_bcd_valid(input bcd_digit_t nib);
        return (nib <= bcd_digit_t'(9));
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD decade register with load/increment/decrement
//
// Purpose : holds a single decimal digit. The parent decides which operation
//           each decade performs; this cell only applies it.
// Ports   :
//   clk  in  rising-edge clock
//   clr  in  synchronous active-high clear (highest priority)
//   inc  in  increment this decade (9 or an illegal nibble goes to 0)
//   dec  in  decrement this decade (0 or an illegal nibble goes to 9)
//   ld   in  load d (beats inc/dec)
//   d    in  load value
//   q    out current digit
//   is9  out digit is 9 or illegal -> passes a carry upward
//   is0  out digit is 0 -> passes a borrow upward
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    input  logic       ld,
    input  bcd_digit_t d,
    output bcd_digit_t q,
    output logic       is9,
    output logic       is0
);

    bcd_digit_t r_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= d;
        end else if (inc) begin
            // illegal nibbles behave as 9 so the count recovers in one step
            r_q <= (r_q >= bcd_digit_t'(9)) ? bcd_digit_t'(0) : r_q + bcd_digit_t'(1);
        end else if (dec) begin
            r_q <= ((r_q == bcd_digit_t'(0)) || (r_q > bcd_digit_t'(9))) ?
                   bcd_digit_t'(9) : r_q - bcd_digit_t'(1);
        end
    end

    assign q   = r_q;
    assign is9 = (r_q >= bcd_digit_t'(9));
    assign is0 = (r_q == bcd_digit_t'(0));

endmodule

// File: rtl/bcd_counter_multi.sv
// rtl/bcd_counter_multi.sv - parametrised multi-digit BCD up/down counter
//
// Purpose : DIGITS decades with lookahead carry/borrow, decimal terminal value
//           MAX_COUNT and wrap (SATURATE=0) or hold (SATURATE=1) at the ends.
// Optional: define BCD_LOAD_CHECK_EN to reject loads with an illegal nibble
//           or a value above MAX_COUNT and flag them on LOAD_ERR.
// Ports   :
//   CLK       in  rising-edge clock
//   CLR       in  synchronous active-high reset
//   ENABLE    in  count/load qualifier
//   LOAD      in  parallel load of D (needs ENABLE)
//   UP        in  1 = up, 0 = down
//   D         in  packed BCD load value, digit 0 in [3:0]
//   Q         out packed BCD count
//   CO        out combinational terminal-count / carry-borrow for cascading
//   LOAD_ERR  out registered rejected-load flag (BCD_LOAD_CHECK_EN only)
module bcd_counter_multi
    import bcd_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int MAX_COUNT = 99,
    parameter int SATURATE  = 0
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  ENABLE,
    input  logic                  LOAD,
    input  logic                  UP,
    input  logic [BCD_W*DIGITS-1:0] D,
    output logic [BCD_W*DIGITS-1:0] Q,
    output logic                  CO
`ifdef BCD_LOAD_CHECK_EN
    ,
    output logic                  LOAD_ERR
`endif
);

    localparam int QW = BCD_W * DIGITS;
    localparam logic [BCD_W*BCD_MAX_DIGITS-1:0] MAX_BCD_FULL = to_bcd(MAX_COUNT);
    localparam logic [QW-1:0] MAX_BCD = MAX_BCD_FULL[QW-1:0];

    logic [QW-1:0]     w_q;
    logic [QW-1:0]     w_ld_val;
    logic              w_ld;
    logic [DIGITS-1:0] w_is9;
    logic [DIGITS-1:0] w_is0;
    logic [DIGITS-1:0] w_low9;
    logic [DIGITS-1:0] w_low0;
    logic [DIGITS-1:0] w_inc;
    logic [DIGITS-1:0] w_dec;
    logic              w_at_term;
    logic              w_zero;
    logic              w_over;

    // Packed BCD orders the same as the decimal value, so plain unsigned
    // compares against MAX_BCD are exact.
    assign w_at_term = (w_q >= MAX_BCD);
    assign w_over    = (w_q >  MAX_BCD);
    assign w_zero    = (w_q == '0);

    // Lookahead: decade i sees whether every lower decade is 9 (or 0).
    // Each term is a flat AND of current state, no registered ripple.
    always_comb begin
        logic acc9;
        logic acc0;
        acc9   = 1'b1;
        acc0   = 1'b1;
        w_low9 = '0;
        w_low0 = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_low9[i] = acc9;
            w_low0[i] = acc0;
            acc9      = acc9 & w_is9[i];
            acc0      = acc0 & w_is0[i];
        end
    end

`ifdef BCD_LOAD_CHECK_EN
    logic w_d_bad;
    logic r_load_err;

    always_comb begin
        w_d_bad = (D > MAX_BCD);
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_valid(D[i*BCD_W +: BCD_W])) begin
                w_d_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= ENABLE && LOAD && w_d_bad;
        end
    end

    assign LOAD_ERR = r_load_err;
`endif

    // Per-decade control. Terminal handling is expressed as a load of 0 or
    // MAX_BCD (or as no operation when saturating), which overrides the
    // per-digit increment/decrement.
    always_comb begin
        w_inc    = '0;
        w_dec    = '0;
        w_ld     = 1'b0;
        w_ld_val = D;
        if (ENABLE && LOAD) begin
`ifdef BCD_LOAD_CHECK_EN
            w_ld = !w_d_bad;
`else
            w_ld = 1'b1;
`endif
        end else if (ENABLE) begin
            if (UP) begin
                if (w_at_term) begin
                    if (SATURATE == 0) begin
                        w_ld     = 1'b1;
                        w_ld_val = '0;
                    end
                end else begin
                    w_inc = w_low9;
                end
            end else begin
                if (w_zero) begin
                    if (SATURATE == 0) begin
                        w_ld     = 1'b1;
                        w_ld_val = MAX_BCD;
                    end
                end else if (w_over) begin
                    // only reachable after loading a value above the terminal
                    w_ld     = 1'b1;
                    w_ld_val = MAX_BCD;
                end else begin
                    w_dec = w_low0;
                end
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk (CLK),
            .clr (CLR),
            .inc (w_inc[g]),
            .dec (w_dec[g]),
            .ld  (w_ld),
            .d   (w_ld_val[g*BCD_W +: BCD_W]),
            .q   (w_q[g*BCD_W +: BCD_W]),
            .is9 (w_is9[g]),
            .is0 (w_is0[g])
        );
    end

    assign Q  = w_q;
    assign CO = ENABLE && !LOAD && !CLR && ((UP && w_at_term) || (!UP && w_zero));

endmodule

// File: tb/tb_bcd_counter_multi.sv
// tb/tb_bcd_counter_multi.sv - self-checking bench for bcd_counter_multi
module tb_bcd_counter_multi;

    logic        clk;
    logic        clr;
    logic        en;
    logic        ld;
    logic        up;
    logic [31:0] d;

    logic [7:0]  q0;
    logic [7:0]  q1;
    logic [11:0] q2;
    logic [15:0] q3;
    logic        co0, co1, co2, co3;
`ifdef BCD_LOAD_CHECK_EN
    logic        er0, er1, er2, er3;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bcd_counter_multi #(.DIGITS(2), .MAX_COUNT(99), .SATURATE(0)) u0 (
        .CLK(clk), .CLR(clr), .ENABLE(en), .LOAD(ld), .UP(up), .D(d[7:0]),
        .Q(q0), .CO(co0)
`ifdef BCD_LOAD_CHECK_EN
        , .LOAD_ERR(er0)
`endif
    );
    bcd_counter_multi #(.DIGITS(2), .MAX_COUNT(59), .SATURATE(0)) u1 (
        .CLK(clk), .CLR(clr), .ENABLE(en), .LOAD(ld), .UP(up), .D(d[7:0]),
        .Q(q1), .CO(co1)
`ifdef BCD_LOAD_CHECK_EN
        , .LOAD_ERR(er1)
`endif
    );
    bcd_counter_multi #(.DIGITS(3), .MAX_COUNT(999), .SATURATE(1)) u2 (
        .CLK(clk), .CLR(clr), .ENABLE(en), .LOAD(ld), .UP(up), .D(d[11:0]),
        .Q(q2), .CO(co2)
`ifdef BCD_LOAD_CHECK_EN
        , .LOAD_ERR(er2)
`endif
    );
    bcd_counter_multi #(.DIGITS(4), .MAX_COUNT(5000), .SATURATE(0)) u3 (
        .CLK(clk), .CLR(clr), .ENABLE(en), .LOAD(ld), .UP(up), .D(d[15:0]),
        .Q(q3), .CO(co3)
`ifdef BCD_LOAD_CHECK_EN
        , .LOAD_ERR(er3)
`endif
    );

    logic [31:0] dq [4];
    logic [3:0]  dco;
    logic [3:0]  der;
    assign dq[0] = {24'b0, q0};
    assign dq[1] = {24'b0, q1};
    assign dq[2] = {20'b0, q2};
    assign dq[3] = {16'b0, q3};
    assign dco   = {co3, co2, co1, co0};
`ifdef BCD_LOAD_CHECK_EN
    assign der   = {er3, er2, er1, er0};
`else
    assign der   = 4'b0;
`endif

    // ---------------- behavioural model ----------------
    function automatic int p_dig(input int k);
        case (k)
            0: return 2;
            1: return 2;
            2: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int p_max(input int k);
        case (k)
            0: return 99;
            1: return 59;
            2: return 999;
            default: return 5000;
        endcase
    endfunction

    function automatic bit p_sat(input int k);
        return (k == 2);
    endfunction

    function automatic logic [31:0] msk(input int n);
        return (n >= 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * n)) - 32'h1);
    endfunction

    // decimal value; an illegal nibble counts as 9
    function automatic int to_int(input logic [31:0] b, input int n);
        int v;
        int dg;
        v = 0;
        for (int i = n - 1; i >= 0; i--) begin
            dg = int'(b[4*i +: 4]);
            if (dg > 9) dg = 9;
            v = v * 10 + dg;
        end
        return v;
    endfunction

    function automatic logic [31:0] to_bcd_n(input int v, input int n);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit all_valid(input logic [31:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            if (b[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    logic [31:0] mq  [4];
    bit          merr[4];

    task automatic mstep(input int k);
        int n, mx, qv;
        logic [31:0] dk;
        n  = p_dig(k);
        mx = p_max(k);
        dk = d & msk(n);
        qv = to_int(mq[k], n);
        if (clr) begin
            mq[k] = '0;
            merr[k] = 1'b0;
        end else if (!en) begin
            merr[k] = 1'b0;
        end else if (ld) begin
`ifdef BCD_LOAD_CHECK_EN
            if (!all_valid(dk, n) || to_int(dk, n) > mx) begin
                merr[k] = 1'b1;
            end else begin
                mq[k] = dk;
                merr[k] = 1'b0;
            end
`else
            mq[k] = dk;
            merr[k] = 1'b0;
`endif
        end else begin
            merr[k] = 1'b0;
            if (up) begin
                if (qv >= mx) mq[k] = p_sat(k) ? mq[k] : 32'h0;
                else          mq[k] = to_bcd_n(qv + 1, n);
            end else begin
                if (mq[k] == 32'h0) mq[k] = p_sat(k) ? 32'h0 : to_bcd_n(mx, n);
                else if (qv > mx)   mq[k] = to_bcd_n(mx, n);
                else                mq[k] = to_bcd_n(qv - 1, n);
            end
        end
    endtask

    function automatic logic mco(input int k);
        int qv;
        qv = to_int(mq[k], p_dig(k));
        return en && !ld && !clr && (up ? (qv >= p_max(k)) : (mq[k] == 32'h0));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // compare process: model advances on every edge, outputs checked 1 time unit later
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) mstep(k);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("model_q%0d", k), dq[k], mq[k]);
            chk($sformatf("model_co%0d", k), {31'b0, dco[k]}, {31'b0, mco(k)});
`ifdef BCD_LOAD_CHECK_EN
            chk($sformatf("model_err%0d", k), {31'b0, der[k]}, {31'b0, merr[k]});
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input bit c, input bit e, input bit l, input bit u, input logic [31:0] dd);
        clr = c; en = e; ld = l; up = u; d = dd;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        set_in(1, 0, 0, 0, 32'h0);
        tick;
        chk("reset_q0", dq[0], 32'h0);
        chk("reset_q3", dq[3], 32'h0);
        chk("reset_co0", {31'b0, co0}, 32'h0);

        // full ramp of the 00..99 counter
        set_in(0, 1, 0, 1, 32'h0);
        for (int i = 1; i <= 100; i++) begin
            tick;
            if (i == 50) chk("ramp_q50", dq[0], 32'h50);
            if (i == 98) chk("ramp_co98", {31'b0, co0}, 32'h0);
            if (i == 99) begin
                chk("ramp_q99", dq[0], 32'h99);
                chk("ramp_co99", {31'b0, co0}, 32'h1);
            end
            if (i == 100) chk("ramp_wrap", dq[0], 32'h0);
        end

        // 0..59 wrap
        set_in(0, 1, 1, 1, 32'h58); tick;
        chk("m59_load", dq[1], 32'h58);
        set_in(0, 1, 0, 1, 32'h0);  tick;
        chk("m59_q59", dq[1], 32'h59);
        chk("m59_co", {31'b0, co1}, 32'h1);
        tick; chk("m59_q00", dq[1], 32'h0);
        tick; chk("m59_q01", dq[1], 32'h01);
        set_in(0, 1, 1, 0, 32'h0); tick;
        set_in(0, 1, 0, 0, 32'h0); #1;
        chk("m59_dn_co", {31'b0, co1}, 32'h1);
        tick; chk("m59_dn_wrap", dq[1], 32'h59);

        // saturating 000..999
        set_in(0, 1, 1, 1, 32'h998); tick;
        set_in(0, 1, 0, 1, 32'h0);
        for (int i = 0; i < 4; i++) tick;
        chk("sat_hold", dq[2], 32'h999);
        chk("sat_co", {31'b0, co2}, 32'h1);
        set_in(0, 1, 1, 0, 32'h0); tick;
        set_in(0, 1, 0, 0, 32'h0); #1;
        chk("sat_dn_co", {31'b0, co2}, 32'h1);
        tick; chk("sat_dn_hold", dq[2], 32'h0);

        // priority
        set_in(0, 1, 1, 1, 32'h42); tick;
        set_in(0, 0, 1, 1, 32'h17); tick;
        chk("pri_hold", dq[0], 32'h42);
        chk("pri_hold_co", {31'b0, co0}, 32'h0);
        set_in(1, 1, 1, 1, 32'h17); tick;
        chk("pri_clr", dq[0], 32'h0);
        set_in(0, 1, 1, 1, 32'h17); #1;
        chk("pri_ld_co", {31'b0, co0}, 32'h0);
        tick; chk("pri_ld", dq[0], 32'h17);

        // borrow chain
        set_in(0, 1, 1, 0, 32'h1000); tick;
        set_in(0, 1, 0, 0, 32'h0); tick;
        chk("borrow_0999", dq[3], 32'h0999);
        set_in(0, 1, 1, 0, 32'h0); tick;
        set_in(0, 1, 0, 0, 32'h0); tick;
        chk("borrow_wrap", dq[3], 32'h5000);

        // illegal nibble load
        set_in(0, 1, 1, 1, 32'h25); tick;
        chk("ld25", dq[0], 32'h25);
        set_in(0, 1, 1, 1, 32'h3A); tick;
`ifdef BCD_LOAD_CHECK_EN
        chk("ld3A_reject", dq[0], 32'h25);
        chk("ld3A_err", {31'b0, er0}, 32'h1);
        set_in(0, 1, 0, 1, 32'h0); tick;
        chk("ld3A_err_clr", {31'b0, er0}, 32'h0);
        chk("ld3A_next", dq[0], 32'h26);
`else
        chk("ld3A_raw", dq[0], 32'h3A);
        set_in(0, 1, 0, 1, 32'h0); tick;
        chk("ld3A_up", dq[0], 32'h40);
`endif

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] rd;
            for (int i = 0; i < 8; i++) rd[4*i +: 4] = 4'($urandom_range(0, 9));
`ifdef BCD_LOAD_CHECK_EN
            if ($urandom_range(0, 7) == 0) rd[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
`endif
            set_in($urandom_range(0, 63) == 0,
                   $urandom_range(0, 7) != 0,
                   $urandom_range(0, 15) == 0,
                   (c % 400) < 200 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0),
                   rd);
            tick;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
